// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// pll_reset_sequencer: holds the PLL in reset, qualifies lock, then releases domain resets one at a time.
// Rev 1.0
module pll_reset_sequencer #(
  parameter int NUM_DOMAINS         = 5,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                             refclk,
  input  logic                             rst,
  input  logic                             locked,
  input  logic                             relock_req,
  output logic                             pll_rst,
  output logic [NUM_DOMAINS-1:0]           dom_rst,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int RST_W      = $clog2(PLL_RST_CYCLES + 1);
  localparam int TO_W       = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int STB_W      = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int REL_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int REL_W      = $clog2(REL_CYCLES + 1);
  localparam int RTY_W      = $clog2(MAX_RETRIES + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_MAX  = REL_W'(REL_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [STB_W-1:0] stb_cnt;
  logic [REL_W-1:0] rel_cnt;
  logic [1:0]       lock_sync;
  logic             locked_s;
  logic             to_done;
  logic             restart;

  always_ff @(posedge refclk) begin
    lock_sync <= {lock_sync[0], locked};
  end

  assign locked_s = lock_sync[1];
  assign to_done  = (to_cnt == TO_LAST);

  // Every path that re-enters RESET_PLL from a running state funnels through restart.
  always_comb begin
    restart = 1'b0;
    case (state)
      S_RESET_PLL: restart = relock_req;
      S_WAIT_LOCK: restart = relock_req || (!locked_s && to_done && (retry_cnt != RTY_MAX));
      S_STABLE:    restart = relock_req;
      S_RELEASE:   restart = relock_req || !locked_s;
      S_RUN:       restart = relock_req || !locked_s;
      S_FAULT:     restart = relock_req;
      default:     restart = 1'b1;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      stb_cnt   <= '0;
      rel_cnt   <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else if (restart) begin
      state   <= S_RESET_PLL;
      rst_cnt <= '0;
      pll_rst <= 1'b1;
      dom_rst <= '1;
      ready   <= 1'b0;
      fault   <= 1'b0;
      if (state == S_FAULT) begin
        retry_cnt <= '0;
      end else if (state == S_WAIT_LOCK && !relock_req) begin
        // Only a lock timeout reaches here; restart already excludes retry_cnt == MAX.
        retry_cnt <= retry_cnt + RTY_W'(1);
      end
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            pll_rst <= 1'b0;
            to_cnt  <= '0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state   <= S_STABLE;
            stb_cnt <= '0;
          end else if (to_done) begin
            state   <= S_FAULT;
            pll_rst <= 1'b1;
            fault   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state  <= S_WAIT_LOCK;
            to_cnt <= '0;
          end else if (stb_cnt == STB_LAST) begin
            state   <= S_RELEASE;
            rel_cnt <= '0;
          end else begin
            stb_cnt <= stb_cnt + STB_W'(1);
          end
        end
        S_RELEASE: begin
          if (!dom_rst[NUM_DOMAINS-1]) begin
            state     <= S_RUN;
            ready     <= 1'b1;
            retry_cnt <= '0;
          end else begin
            if (rel_cnt != REL_MAX) begin
              rel_cnt <= rel_cnt + REL_W'(1);
            end
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (int'(rel_cnt) == (k + 1) * STAGGER_CYCLES - 1) begin
                dom_rst[k] <= 1'b0;
              end
            end
          end
        end
        S_RUN: begin
        end
        S_FAULT: begin
        end
        default: begin
          state   <= S_RESET_PLL;
          rst_cnt <= '0;
          pll_rst <= 1'b1;
          dom_rst <= '1;
          ready   <= 1'b0;
          fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controls the board PLL through its reset and lock signals, and generates one reset per derived clock domain. It holds the PLL in reset, waits for a lock that is both timely and stable, then releases the domain resets one at a time in a staggered order. It re-runs the sequence on loss of lock or on software request, and latches a fault after repeated lock timeouts. It runs on the PLL reference clock and sits between the top-level reset pin and every outclk-domain reset synchronizer.

Parameters:
NUM_DOMAINS, 5, number of domain resets (one per PLL output clock)
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt
LOCK_TIMEOUT_CYCLES, 100000, max cycles in WAIT_LOCK before a retry
LOCK_STABLE_CYCLES, 1024, consecutive cycles locked_s must be high before release
STAGGER_CYCLES, 8, cycles between successive domain reset releases
MAX_RETRIES, 3, lock timeouts tolerated before FAULT

Ports:
refclk  input  1  reference clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
locked  input  1  PLL lock, asynchronous; pass through a 2-flop synchronizer to form locked_s
relock_req  input  1  single-cycle pulse; forces a full re-sequence and clears FAULT
pll_rst  output  1  active-high reset to the PLL
dom_rst  output  NUM_DOMAINS  active-high per-domain resets; bit i is for outclk_i
ready  output  1  high only in RUN, once all dom_rst are low
fault  output  1  high only in FAULT
retry_cnt  output  clog2(MAX_RETRIES+1)  lock timeouts in the current episode

Behaviour:
- All outputs are registered. Counter widths are clog2(param+1). Counters saturate and never wrap.
- rst=1 (sync) puts the FSM in RESET_PLL with counters cleared. Outputs on reset: pll_rst=1, dom_rst=all 1s, ready=0, fault=0, retry_cnt=0. rst mid-sequence aborts immediately the same way.
- locked_s lags locked by 2 cycles. All decisions use locked_s only.
- RESET_PLL: pll_rst=1, dom_rst=all 1s. After exactly PLL_RST_CYCLES cycles go to WAIT_LOCK; pll_rst drops on that edge.
- WAIT_LOCK: pll_rst=0, timeout counter counting.
  - locked_s=1 -> STABLE, stable counter cleared.
  - Timeout counter reaches LOCK_TIMEOUT_CYCLES: if retry_cnt==MAX_RETRIES -> FAULT; otherwise retry_cnt+1 -> RESET_PLL.
- STABLE: requires locked_s high for LOCK_STABLE_CYCLES consecutive cycles, then -> RELEASE. Any low cycle -> WAIT_LOCK with the timeout counter restarted.
- RELEASE: dom_rst[k] goes low exactly (k+1)*STAGGER_CYCLES cycles after entry, in index order 0 first. Once a bit is released it stays low. The cycle after dom_rst[NUM_DOMAINS-1] falls: -> RUN, ready=1, retry_cnt cleared.
- RUN: steady state. locked_s=0 or relock_req=1 -> RESET_PLL. On the next edge all dom_rst=1 and ready=0 together; no stagger on assertion.
- Loss of locked_s during RELEASE -> RESET_PLL. All dom_rst reassert on the next edge. retry_cnt is unchanged.
- FAULT: pll_rst=1, dom_rst=all 1s, fault=1, ready=0. Exit only via rst, or via relock_req, which clears retry_cnt and fault and goes to RESET_PLL.
- relock_req in RESET_PLL, WAIT_LOCK or STABLE: restart RESET_PLL from count 0. retry_cnt is unchanged.
- rst and relock_req in the same cycle: rst wins.
- Invariant: ready=1 implies pll_rst=0, dom_rst=0 and fault=0.

Test Plan:
Bench parameters: NUM_DOMAINS=5, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8, STAGGER_CYCLES=2, MAX_RETRIES=2.
1. Nominal: rst pulse, then locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles. dom_rst falls bit-by-bit at 2, 4, 6, 8, 10 cycles after RELEASE entry. ready=1 one cycle after the bit-4 release. retry_cnt=0.
2. Glitchy lock: locked high 5 cycles, low 1 cycle, then high steady -> no release until 8 consecutive high cycles of locked_s. dom_rst stays 5'b11111 throughout the glitch.
3. Timeouts to fault: locked held 0 -> retry_cnt steps 1, 2, each step followed by a fresh 4-cycle pll_rst pulse. After the third 50-cycle timeout: fault=1, pll_rst=1, ready=0. relock_req then clears fault and retry_cnt=0.
4. Loss of lock in RUN: drop locked -> 2 cycles of sync latency, then on the next edge dom_rst=5'b11111 and ready=0. pll_rst pulses 4 cycles and the full sequence repeats.
5. Lock loss mid-RELEASE after dom_rst=5'b11100 -> next state gives dom_rst=5'b11111 and RESET_PLL. retry_cnt is unchanged.
6. rst asserted during STABLE together with relock_req -> reset values on the next edge: pll_rst=1, dom_rst=5'b11111, fault=0, retry_cnt=0.
